// File: rtl/vtg_mux_arb.sv
// Two-requester round-robin arbiter driving the vtg_mux select line.
// A one-cycle gap separates every change of owner, and a hold limit bounds each grant.
module vtg_mux_arb #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic sel,
    output logic valid,
    output logic preempt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT0,
        S_GRANT1,
        S_GAP
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic             pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] req;
    logic       own;
    logic       req_own;
    logic       req_oth;
    logic       pick;

    assign req     = {req1, req0};
    assign own     = (state_q == S_GRANT1);
    assign req_own = req[own];
    assign req_oth = req[~own];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        pre_d   = 1'b0;
        cnt_d   = cnt_q;
        pick    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    pick    = (req0 && req1) ? ~last_q : req1;
                    state_d = pick ? S_GRANT1 : S_GRANT0;
                    last_d  = pick;
                    sel_d   = pick;
                    cnt_d   = '0;
                end
            end
            S_GRANT0, S_GRANT1: begin
                if (cnt_q != HOLD_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!req_own) begin
                    if (req_oth) begin
                        state_d = S_GAP;
                        sel_d   = ~own;
                    end else begin
                        state_d = S_IDLE;
                    end
                // >= so a late-arriving waiter still preempts a saturated owner
                end else if (req_oth && (cnt_q >= HOLD_LIM)) begin
                    state_d = S_GAP;
                    sel_d   = ~own;
                    pre_d   = 1'b1;
                end
            end
            S_GAP: begin
                cnt_d = '0;
                if (req[~last_q]) begin
                    pick    = ~last_q;
                    state_d = pick ? S_GRANT1 : S_GRANT0;
                    last_d  = pick;
                    sel_d   = pick;
                end else if (req[last_q]) begin
                    // target gave up; hand the mux back to the former owner
                    pick    = last_q;
                    state_d = pick ? S_GRANT1 : S_GRANT0;
                    sel_d   = pick;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            pre_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt0    = (state_q == S_GRANT0);
    assign gnt1    = (state_q == S_GRANT1);
    assign valid   = gnt0 | gnt1;
    assign sel     = sel_q;
    assign preempt = pre_q;

endmodule

// File: tb/tb_vtg_mux_arb.sv
// Scoreboard bench for vtg_mux_arb: directed request vectors with
// hand-computed expected grant/sel/valid/preempt values.
module tb_vtg_mux_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0 = 1'b0;
    logic req1 = 1'b0;
    logic gnt0, gnt1, sel, valid, preempt;

    int checks = 0;
    int errors = 0;

    logic [4:0] expq[$];

    always #5 clk = ~clk;

    vtg_mux_arb #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .req0(req0),
        .req1(req1),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .sel(sel),
        .valid(valid),
        .preempt(preempt)
    );

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got g0g1 sel v p=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r0, input logic r1, input logic g0,
                        input logic g1, input logic s, input logic p);
        @(negedge clk);
        req0 = r0;
        req1 = r1;
        expq.push_back({g0, g1, s, g0 | g1, p});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", expq.size());
            expq.delete();
        end
    endtask

    // monitor: pops one expectation per edge, checks invariants every edge
    logic pv = 1'b0;
    logic ps = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (!rst && valid && pv) begin
            checks++;
            if (sel !== ps) begin
                errors++;
                $display("FAIL sel_stable: got %b required %b", sel, ps);
            end
        end
        pv = valid;
        ps = sel;
        if (expq.size() != 0) begin
            logic [4:0] e;
            e = expq.pop_front();
            chk("scoreboard", {gnt0, gnt1, sel, valid, preempt}, e);
            checks++;
            if (gnt0 && gnt1) begin
                errors++;
                $display("FAIL overlap: got gnt0=%b gnt1=%b required not both", gnt0, gnt1);
            end
        end
    end

    initial begin
        // reset with random requests
        rst  = 1'b1;
        req0 = 1'($urandom);
        req1 = 1'($urandom);
        repeat (3) @(negedge clk);
        chk("reset", {gnt0, gnt1, sel, valid, preempt}, 5'b00000);
        rst  = 1'b0;
        req0 = 1'b1;
        req1 = 1'b0;
        expq.push_back(5'b10010);
        step(0, 0, 0, 0, 0, 0);

        // single requester 1 for five cycles
        repeat (5) step(0, 1, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // tie: last=1 so requester 0 wins, then release handover via gap
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 1, 1, 0);
        step(0, 1, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // contention: 8 grant cycles then 1 preempt gap, alternating owners
        for (int i = 0; i <= 40; i++) begin
            int ph;
            logic o;
            ph = i % 9;
            o  = 1'((i / 9) % 2);
            if (ph == 8) begin
                step(1, 1, 0, 0, ~o, 1);
            end else begin
                step(1, 1, ~o, o, o, 0);
            end
        end
        step(0, 0, 0, 0, 0, 0);

        // gap abort: target drops during the gap
        step(1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // async reset mid-grant
        step(0, 1, 0, 1, 1, 0);
        step(0, 1, 0, 1, 1, 0);
        drain();
        @(negedge clk);
        #2;
        chk("pre_reset_grant", {gnt0, gnt1, sel, valid, preempt}, 5'b01110);
        rst = 1'b1;
        #1;
        chk("async_reset", {gnt0, gnt1, sel, valid, preempt}, 5'b00000);
        @(negedge clk);
        rst  = 1'b0;
        req0 = 1'b1;
        req1 = 1'b0;
        expq.push_back(5'b10010);
        step(0, 0, 0, 0, 0, 0);
        drain();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
